sdram_phy_rdtrack: RTL and testbench
====================================

// Module: sdram_phy_rdtrack
// PURPOSE
//  Parametrised SDRAM PHY: registers command/address/data onto pad-side signals, adds multi-rank chip select, and tracks
//  issued READ commands so read data returns to the controller with a valid strobe after programmable CAS latency.
//  Pad side is split o/oe/i (no inout) so full-system 2-state simulation works; tristate cells sit in the FPGA top level.
// PARAMETERS
//  W_SDRAM_BANKSEL  2   bank select width
//  W_SDRAM_ADDR     13  address width
//  W_SDRAM_DATA     16  DQ width, multiple of 8
//  N_RANKS          1   chip selects, 1..4
//  BURST_LEN        1   beats per READ, 1/2/4/8 (must match mode register)
//  RD_EXTRA_DELAY   0   extra capture stages after DQ input register, 0..3
// PORTS
//  clk              in   1              system clock; all logic posedge
//  rst              in   1              synchronous, active-high reset
//  cfg_cas_latency  in   2              CL, legal 2 or 3; change only when no read in flight
//  ctrl_clk_enable  in   1              SDRAM clock gate
//  ctrl_cs_n_next   in   N_RANKS        per-rank chip select, active low
//  ctrl_ras_n_next / ctrl_cas_n_next / ctrl_we_n_next / ctrl_clke_next  in 1 each  command
//  ctrl_ba_next     in   W_SDRAM_BANKSEL
//  ctrl_a_next      in   W_SDRAM_ADDR
//  ctrl_dqm_next    in   W_SDRAM_DATA/8
//  ctrl_dq_o_next   in   W_SDRAM_DATA   write data
//  ctrl_dq_oe_next  in   1              drive DQ
//  ctrl_rdata       out  W_SDRAM_DATA   captured read beat
//  ctrl_rdata_valid out  1              ctrl_rdata is a burst beat this cycle
//  ctrl_rd_busy     out  1              any READ in flight (cfg change forbidden)
//  err_bus_conflict out  1              sticky; see CONFIGURATION
//  pad_clk_en, pad_cs_n[N_RANKS], pad_ras_n, pad_cas_n, pad_we_n, pad_clke, pad_ba, pad_a, pad_dqm  out  registered copies
//  pad_dq_o         out  W_SDRAM_DATA   pad_dq_oe  out 1   pad_dq_i  in W_SDRAM_DATA
// BEHAVIOUR
//  - All pad_* outputs: one register stage from *_next. Reset values: cs_n all 1, ras/cas/we_n 1, clke 0, clk_en 0,
//    dqm all 1, a/ba/dq_o 0, dq_oe 0. ctrl_rdata 0, ctrl_rdata_valid 0, ctrl_rd_busy 0, err 0.
//  - Decode on registered pad values (cycle P): READ = any cs_n low, ras_n 1, cas_n 0, we_n 1; BTERM = ras_n 1, cas_n 1, we_n 0.
//  - pad_dq_i sampled every cycle into capture reg, then RD_EXTRA_DELAY stages -> ctrl_rdata.
//  - READ at pad cycle P: first valid beat at P+CL+1+RD_EXTRA_DELAY; i.e. *_next presented at T -> valid at T+2+CL+RD_EXTRA_DELAY.
//  - Delay line (depth 3+3+1) carries READ/BTERM tokens; tap selected by cfg_cas_latency. At READ tap: beat counter := BURST_LEN.
//    Valid high while counter != 0; decrements each cycle.
//  - READ token arriving while counter != 0: reload BURST_LEN (seamless every BURST_LEN cycles; earlier = truncate old burst).
//  - BTERM token at tap: counter := 0 same cycle; READ+BTERM same tap impossible (single command per cycle).
//  - ctrl_rd_busy = any token in delay line OR counter != 0.
//  - rst mid-burst: tokens and counter cleared, valid low from the cycle after rst sampled; pads to reset values.
//  - cfg_cas_latency changed while busy, or =0/1: undefined data, no X on outputs; treat 0/1 as 2.
// CONFIGURATION
//  SDRAM_PHY_CONFLICT_CHECK_EN defined: err_bus_conflict sets when pad_dq_oe=1 in a cycle the device is driving read
//  data (beat counter at pad timing, i.e. P+CL..P+CL+BURST_LEN-1); cleared only by rst.
//  Not defined: err_bus_conflict tied 0, no checking logic.
// STRUCTURE
//  - Shared package sdram_pkg: command encodings (CMD_READ, CMD_BTERM, CMD_NOP...), CL range constants, MAX_RD_LAT.
//  - One sub-module: sdram_rd_tracker (delay line, tap mux, beat counter, busy, conflict window). Pad regs/capture inline.
// TESTING
//  - Reset: rst 1 for 2 cycles -> all pads at reset values, valid 0, busy 0.
//  - CL=2, BURST_LEN=4, RD_EXTRA_DELAY=0: READ at T -> valid T+4..T+7, rdata = pad_dq_i driven at T+3..T+6 (0x1111..0x4444).
//  - CL=3, BURST_LEN=4, READs at T and T+4 -> 8 contiguous valid beats from T+5; READ at T+2 instead -> 2+4 beats.
//  - CL=2, BURST_LEN=8, READ at T, BTERM at T+3 -> valid T+4..T+6 only, busy low at T+7.
//  - rst asserted at T+5 of 8-beat burst -> valid low from T+6, busy 0, later READ works normally.
//  - CONFLICT_CHECK_EN: dq_oe_next at T+2 after READ at T (CL=2) -> err 1 and stays; without macro err stays 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM PHY definitions: command encodings, CAS latency range and read latency bounds.
package sdram_pkg;

    // Command encoding on {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS       = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BTERM     = 3'b110,
        CMD_NOP       = 3'b111
    } sdram_cmd_e;

    localparam int CL_MIN       = 2;
    localparam int CL_MAX       = 3;
    localparam int RD_EXTRA_MAX = 3;
    // Worst-case pad-cycle-to-valid latency: CL + capture register + extra stages
    localparam int MAX_RD_LAT   = CL_MAX + RD_EXTRA_MAX + 1;

    // Only CL 2 and 3 are supported; anything other than 3 behaves as 2
    function automatic logic [2:0] cl_effective(input logic [1:0] cl);
        return (cl == 2'd3) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/sdram_rd_tracker.sv
// Read return tracker: command token delay line, CL-selected tap, beat counter, busy flag.
// Optional bus conflict detector enabled by SDRAM_PHY_CONFLICT_CHECK_EN.
module sdram_rd_tracker
    import sdram_pkg::*;
#(
    parameter int BURST_LEN      = 1,
    parameter int RD_EXTRA_DELAY = 0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg_cas_latency,
    input  logic       cmd_read,
    input  logic       cmd_bterm,
`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    input  logic       pad_dq_oe,
    output logic       err_bus_conflict,
`endif
    output logic       rdata_valid,
    output logic       rd_busy
);

    // Deepest tap is CL_MAX + RD_EXTRA_DELAY - 1, so the line needs no more stages than this
    localparam int DEPTH = CL_MAX + RD_EXTRA_DELAY;
    localparam int W_CNT = 4;

    logic [DEPTH-1:0] rd_line_reg;
    logic [DEPTH-1:0] bt_line_reg;
    logic [DEPTH-1:0] tap_sel;
    logic [DEPTH-1:0] pending;
    logic [2:0]       cl_eff;
    logic [2:0]       tap;
    logic             rd_tap;
    logic             bt_tap;
    logic [W_CNT-1:0] beat_cnt_reg;
    logic [W_CNT-1:0] beat_cnt_next;

    // BTERM wins over everything, READ (re)loads a full burst, otherwise count down
    function automatic logic [W_CNT-1:0] beat_step(input logic [W_CNT-1:0] cur,
                                                   input logic rd, input logic bt);
        if (bt)
            return '0;
        else if (rd)
            return W_CNT'(BURST_LEN);
        else if (cur != '0)
            return cur - 1'b1;
        return cur;
    endfunction

    assign cl_eff = cl_effective(cfg_cas_latency);
    // Token at index k is visible k+1 cycles after the pad command; the counter
    // adds one more register, so the tap is CL + extra - 1
    assign tap    = cl_eff + 3'(RD_EXTRA_DELAY) - 3'd1;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign tap_sel[gi] = (tap == 3'(gi));
            // Tokens past the tap have already been consumed and do not count as in flight
            assign pending[gi] = (rd_line_reg[gi] | bt_line_reg[gi]) & (tap >= 3'(gi));
        end
    endgenerate

    assign rd_tap = |(rd_line_reg & tap_sel);
    assign bt_tap = |(bt_line_reg & tap_sel);

    // Next beat count from the selected tap
    always_comb begin
        beat_cnt_next = beat_step(beat_cnt_reg, rd_tap, bt_tap);
    end

    // Token delay line and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_line_reg  <= '0;
            bt_line_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            rd_line_reg  <= {rd_line_reg[DEPTH-2:0], cmd_read};
            bt_line_reg  <= {bt_line_reg[DEPTH-2:0], cmd_bterm};
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    assign rdata_valid = (beat_cnt_reg != '0);
    assign rd_busy     = cmd_read | (|pending) | (beat_cnt_reg != '0);

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    logic [W_CNT-1:0] pad_cnt_reg;
    logic             pad_rd_tap;
    logic             pad_bt_tap;
    logic             err_reg;

    // Second counter aligned to when the device actually drives DQ (P+CL onwards)
    assign pad_rd_tap = (cl_eff == 3'd3) ? rd_line_reg[1] : rd_line_reg[0];
    assign pad_bt_tap = (cl_eff == 3'd3) ? bt_line_reg[1] : bt_line_reg[0];

    // Device-drive window counter and sticky conflict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            pad_cnt_reg <= beat_step(pad_cnt_reg, pad_rd_tap, pad_bt_tap);
            err_reg     <= err_reg | (pad_dq_oe & (pad_cnt_reg != '0));
        end
    end

    assign err_bus_conflict = err_reg;
`endif

endmodule

// File: rtl/sdram_phy_rdtrack.sv
// SDRAM PHY top: pad-side command/address/data registers, DQ capture chain, read return tracking.
// Optional feature macro: SDRAM_PHY_CONFLICT_CHECK_EN (bus conflict detector; err tied 0 otherwise).
module sdram_phy_rdtrack
    import sdram_pkg::*;
#(
    parameter int W_SDRAM_BANKSEL = 2,
    parameter int W_SDRAM_ADDR    = 13,
    parameter int W_SDRAM_DATA    = 16,
    parameter int N_RANKS         = 1,
    parameter int BURST_LEN       = 1,
    parameter int RD_EXTRA_DELAY  = 0
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  cfg_cas_latency,
    input  logic                        ctrl_clk_enable,
    input  logic [N_RANKS-1:0]          ctrl_cs_n_next,
    input  logic                        ctrl_ras_n_next,
    input  logic                        ctrl_cas_n_next,
    input  logic                        ctrl_we_n_next,
    input  logic                        ctrl_clke_next,
    input  logic [W_SDRAM_BANKSEL-1:0]  ctrl_ba_next,
    input  logic [W_SDRAM_ADDR-1:0]     ctrl_a_next,
    input  logic [W_SDRAM_DATA/8-1:0]   ctrl_dqm_next,
    input  logic [W_SDRAM_DATA-1:0]     ctrl_dq_o_next,
    input  logic                        ctrl_dq_oe_next,
    output logic [W_SDRAM_DATA-1:0]     ctrl_rdata,
    output logic                        ctrl_rdata_valid,
    output logic                        ctrl_rd_busy,
    output logic                        err_bus_conflict,
    output logic                        pad_clk_en,
    output logic [N_RANKS-1:0]          pad_cs_n,
    output logic                        pad_ras_n,
    output logic                        pad_cas_n,
    output logic                        pad_we_n,
    output logic                        pad_clke,
    output logic [W_SDRAM_BANKSEL-1:0]  pad_ba,
    output logic [W_SDRAM_ADDR-1:0]     pad_a,
    output logic [W_SDRAM_DATA/8-1:0]   pad_dqm,
    output logic [W_SDRAM_DATA-1:0]     pad_dq_o,
    output logic                        pad_dq_oe,
    input  logic [W_SDRAM_DATA-1:0]     pad_dq_i
);

    logic [W_SDRAM_DATA-1:0] cap_reg [RD_EXTRA_DELAY+1];
    logic [2:0]              pad_cmd;
    logic                    cmd_read;
    logic                    cmd_bterm;

    // Single register stage between controller and pads; reset leaves the device deselected
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_clk_en <= 1'b0;
            pad_cs_n   <= '1;
            pad_ras_n  <= 1'b1;
            pad_cas_n  <= 1'b1;
            pad_we_n   <= 1'b1;
            pad_clke   <= 1'b0;
            pad_ba     <= '0;
            pad_a      <= '0;
            pad_dqm    <= '1;
            pad_dq_o   <= '0;
            pad_dq_oe  <= 1'b0;
        end else begin
            pad_clk_en <= ctrl_clk_enable;
            pad_cs_n   <= ctrl_cs_n_next;
            pad_ras_n  <= ctrl_ras_n_next;
            pad_cas_n  <= ctrl_cas_n_next;
            pad_we_n   <= ctrl_we_n_next;
            pad_clke   <= ctrl_clke_next;
            pad_ba     <= ctrl_ba_next;
            pad_a      <= ctrl_a_next;
            pad_dqm    <= ctrl_dqm_next;
            pad_dq_o   <= ctrl_dq_o_next;
            pad_dq_oe  <= ctrl_dq_oe_next;
        end
    end

    // Decode the command actually on the pads; BTERM is not qualified by chip select
    assign pad_cmd   = {pad_ras_n, pad_cas_n, pad_we_n};
    assign cmd_read  = (pad_cs_n != '1) && (pad_cmd == CMD_READ);
    assign cmd_bterm = (pad_cmd == CMD_BTERM);

    // DQ input register followed by the optional extra capture stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_EXTRA_DELAY; i++)
                cap_reg[i] <= '0;
        end else begin
            cap_reg[0] <= pad_dq_i;
            for (int i = 1; i <= RD_EXTRA_DELAY; i++)
                cap_reg[i] <= cap_reg[i-1];
        end
    end

    assign ctrl_rdata = cap_reg[RD_EXTRA_DELAY];

    sdram_rd_tracker #(
        .BURST_LEN      (BURST_LEN),
        .RD_EXTRA_DELAY (RD_EXTRA_DELAY)
    ) u_rd_tracker (
        .clk              (clk),
        .rst              (rst),
        .cfg_cas_latency  (cfg_cas_latency),
        .cmd_read         (cmd_read),
        .cmd_bterm        (cmd_bterm),
`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
        .pad_dq_oe        (pad_dq_oe),
        .err_bus_conflict (err_bus_conflict),
`endif
        .rdata_valid      (ctrl_rdata_valid),
        .rd_busy          (ctrl_rd_busy)
    );

`ifndef SDRAM_PHY_CONFLICT_CHECK_EN
    assign err_bus_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_phy_rdtrack.sv
// Directed bench for sdram_phy_rdtrack: two instances (BURST_LEN 4 and 8) share one stimulus stream.
module tb_sdram_phy_rdtrack;

    localparam int W  = 16;
    localparam int NR = 2;

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_cl;
    logic          clk_enable;
    logic [NR-1:0] cs_n;
    logic          ras_n, cas_n, we_n, clke;
    logic [1:0]    ba;
    logic [12:0]   a;
    logic [1:0]    dqm;
    logic [W-1:0]  dq_o;
    logic          dq_oe;
    logic [W-1:0]  dq_i;

    logic [W-1:0]  rdata4, rdata8;
    logic          valid4, valid8, busy4, busy8, err4, err8;
    logic          p4_clk_en, p4_ras_n, p4_cas_n, p4_we_n, p4_clke, p4_dq_oe;
    logic [NR-1:0] p4_cs_n;
    logic [1:0]    p4_ba, p4_dqm;
    logic [12:0]   p4_a;
    logic [W-1:0]  p4_dq_o;
    logic          p8_clk_en, p8_ras_n, p8_cas_n, p8_we_n, p8_clke, p8_dq_oe;
    logic [NR-1:0] p8_cs_n;
    logic [1:0]    p8_ba, p8_dqm;
    logic [12:0]   p8_a;
    logic [W-1:0]  p8_dq_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_phy_rdtrack #(.N_RANKS(NR), .BURST_LEN(4), .RD_EXTRA_DELAY(0)) u_dut4 (
        .clk(clk), .rst(rst), .cfg_cas_latency(cfg_cl), .ctrl_clk_enable(clk_enable),
        .ctrl_cs_n_next(cs_n), .ctrl_ras_n_next(ras_n), .ctrl_cas_n_next(cas_n),
        .ctrl_we_n_next(we_n), .ctrl_clke_next(clke), .ctrl_ba_next(ba), .ctrl_a_next(a),
        .ctrl_dqm_next(dqm), .ctrl_dq_o_next(dq_o), .ctrl_dq_oe_next(dq_oe),
        .ctrl_rdata(rdata4), .ctrl_rdata_valid(valid4), .ctrl_rd_busy(busy4),
        .err_bus_conflict(err4), .pad_clk_en(p4_clk_en), .pad_cs_n(p4_cs_n),
        .pad_ras_n(p4_ras_n), .pad_cas_n(p4_cas_n), .pad_we_n(p4_we_n), .pad_clke(p4_clke),
        .pad_ba(p4_ba), .pad_a(p4_a), .pad_dqm(p4_dqm), .pad_dq_o(p4_dq_o),
        .pad_dq_oe(p4_dq_oe), .pad_dq_i(dq_i)
    );

    sdram_phy_rdtrack #(.N_RANKS(NR), .BURST_LEN(8), .RD_EXTRA_DELAY(0)) u_dut8 (
        .clk(clk), .rst(rst), .cfg_cas_latency(cfg_cl), .ctrl_clk_enable(clk_enable),
        .ctrl_cs_n_next(cs_n), .ctrl_ras_n_next(ras_n), .ctrl_cas_n_next(cas_n),
        .ctrl_we_n_next(we_n), .ctrl_clke_next(clke), .ctrl_ba_next(ba), .ctrl_a_next(a),
        .ctrl_dqm_next(dqm), .ctrl_dq_o_next(dq_o), .ctrl_dq_oe_next(dq_oe),
        .ctrl_rdata(rdata8), .ctrl_rdata_valid(valid8), .ctrl_rd_busy(busy8),
        .err_bus_conflict(err8), .pad_clk_en(p8_clk_en), .pad_cs_n(p8_cs_n),
        .pad_ras_n(p8_ras_n), .pad_cas_n(p8_cas_n), .pad_we_n(p8_we_n), .pad_clke(p8_clke),
        .pad_ba(p8_ba), .pad_a(p8_a), .pad_dqm(p8_dqm), .pad_dq_o(p8_dq_o),
        .pad_dq_oe(p8_dq_oe), .pad_dq_i(dq_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge: outputs now show this cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_nop();
        cs_n = '1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic cmd_read(input int rank);
        cs_n = '1; cs_n[rank] = 1'b0; ras_n = 1'b1; cas_n = 1'b0; we_n = 1'b1;
    endtask

    task automatic cmd_bterm();
        cs_n = 2'b10; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        cmd_nop();
        step();
        while ((busy4 || busy8) && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", {30'd0, busy4, busy8}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_cl = 2'd2; cmd_nop(); clk_enable = 1'b1; clke = 1'b1;
        ba = 2'b01; a = 13'h0005; dqm = 2'b00; dq_o = 16'h1234; dq_oe = 1'b0; dq_i = '0;
        step();
        step();
        chk("rst_cs_n",   p4_cs_n, 2'b11);
        chk("rst_cmd",    {p4_ras_n, p4_cas_n, p4_we_n}, 3'b111);
        chk("rst_clke",   p4_clke, 1'b0);
        chk("rst_clk_en", p4_clk_en, 1'b0);
        chk("rst_dqm",    p4_dqm, 2'b11);
        chk("rst_a_ba",   {p4_a, p4_ba}, 15'd0);
        chk("rst_dq",     {p4_dq_o, p4_dq_oe}, 17'd0);
        chk("rst_rdata",  rdata4, 16'd0);
        chk("rst_flags",  {valid4, busy4, err4, valid8, busy8, err8}, 6'd0);
        rst = 1'b0;

        // Pad pass-through, one register stage
        ba = 2'b10; a = 13'h1abc; dqm = 2'b01; dq_o = 16'hbeef; dq_oe = 1'b1; cs_n = 2'b01;
        step();
        step();
        chk("pad_a_ba",   {p4_a, p4_ba}, {13'h1abc, 2'b10});
        chk("pad_dqm",    p4_dqm, 2'b01);
        chk("pad_dq",     {p4_dq_o, p4_dq_oe}, {16'hbeef, 1'b1});
        chk("pad_ctl",    {p4_cs_n, p4_clke, p4_clk_en}, {2'b01, 1'b1, 1'b1});
        ba = '0; a = '0; dqm = '0; dq_o = '0; dq_oe = 1'b0;
        wait_idle();

        // CL=2 single READ, BL4
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) cmd_read(0); else cmd_nop();
            dq_i = (k >= 3 && k <= 6) ? 16'(k - 2) * 16'h1111 : 16'hdead;
            chk("A_valid", valid4, (k >= 4 && k <= 7));
            chk("A_busy", busy4, (k >= 1 && k <= 7));
            if (k >= 4 && k <= 7) chk("A_rdata", rdata4, 16'(k - 3) * 16'h1111);
        end
        wait_idle();

        // CL=3 seamless READs at 0 and 4
        cfg_cl = 2'd3;
        for (int k = 0; k < 15; k++) begin
            step();
            if (k == 0 || k == 4) cmd_read(0); else cmd_nop();
            dq_i = 16'hA000 + 16'(k);
            chk("B1_valid", valid4, (k >= 5 && k <= 12));
            if (k >= 5 && k <= 12) chk("B1_rdata", rdata4, 16'hA000 + 16'(k - 1));
        end
        wait_idle();

        // CL=3 READs at 0 and 2: first burst truncated to 2 beats
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 0 || k == 2) cmd_read(0); else cmd_nop();
            dq_i = 16'hA000 + 16'(k);
            chk("B2_valid", valid4, (k >= 5 && k <= 10));
            if (k >= 5 && k <= 10) chk("B2_rdata", rdata4, 16'hA000 + 16'(k - 1));
        end
        cfg_cl = 2'd2;
        wait_idle();

        // CL=2 READ on rank 1, BTERM at 3
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) cmd_read(1); else if (k == 3) cmd_bterm(); else cmd_nop();
            chk("C_valid8", valid8, (k >= 4 && k <= 6));
            chk("C_busy8", busy8, (k >= 1 && k <= 6));
            chk("C_valid4", valid4, (k >= 4 && k <= 6));
        end
        wait_idle();

        // Reset in the middle of an 8-beat burst
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) cmd_read(0); else cmd_nop();
            rst = (k == 5);
            chk("D_valid8", valid8, (k >= 4 && k <= 5));
            chk("D_busy8", busy8, (k >= 1 && k <= 5));
            if (k == 6) chk("D_rst_pads", {p4_cs_n, p4_clke, p4_dqm}, {2'b11, 1'b0, 2'b11});
            if (k == 7) chk("D_clke_back", p4_clke, 1'b1);
        end
        wait_idle();

        // Normal READ after the reset
        for (int k = 0; k < 14; k++) begin
            step();
            if (k == 0) cmd_read(0); else cmd_nop();
            dq_i = 16'h5000 + 16'(k);
            chk("D2_valid8", valid8, (k >= 4 && k <= 11));
            if (k >= 4 && k <= 11) chk("D2_rdata8", rdata8, 16'h5000 + 16'(k - 1));
        end
        wait_idle();

        // CL code 0 behaves as CL=2
        cfg_cl = 2'd0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) cmd_read(0); else cmd_nop();
            chk("F_valid_cl0", valid4, (k >= 4 && k <= 7));
        end
        cfg_cl = 2'd2;
        wait_idle();

        // Controller drives DQ while the device returns read data
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) cmd_read(0); else cmd_nop();
            dq_oe = (k == 2);
            if (k == 3) chk("E_err_before", {err4, err8}, 2'b00);
            if (k >= 4) chk("E_err", {err4, err8}, {EXP_ERR, EXP_ERR});
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
